// File: rtl/menu_text_buffer_pkg.sv
// Shared types and constants for the menu text buffer: FSM state encoding,
// default geometry and the named character codes used by the menu screens.
package menu_text_buffer_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } menu_state_e;

  localparam int MENU_COLS   = 16;
  localparam int MENU_ROWS   = 16;
  localparam int MENU_CODE_W = 7;
  localparam int MENU_PAGES  = 2;

  localparam logic [MENU_CODE_W-1:0] MENU_FILL_CODE  = 7'h00;
  localparam logic [MENU_CODE_W-1:0] MENU_BLANK_CODE = 7'h20;

  // Page-select width never collapses to zero, even for a single page.
  function automatic int pg_width(input int pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

endpackage

// File: rtl/menu_text_buffer_if.sv
// Bus between the menu/game control logic (master) and the text buffer (slave),
// plus the display read port and a debug view of the buffer FSM.
interface menu_text_buffer_if
  import menu_text_buffer_pkg::*;
#(
  parameter int XY_W   = 8,
  parameter int PG_W   = 1,
  parameter int CODE_W = 7
);
  logic [XY_W-1:0]   char_xy;
  logic [PG_W-1:0]   page_sel;
  logic [CODE_W-1:0] char_code;

  // Write handshake: a cell write transfers on a clock edge where wr_en and
  // wr_ready are both high; the master holds wr_en/wr_page/wr_xy/wr_code
  // stable until then. clr_req is a single-cycle request sampled only when
  // the buffer is idle; requests seen while busy are dropped, not queued.
  logic              wr_en;
  logic [PG_W-1:0]   wr_page;
  logic [XY_W-1:0]   wr_xy;
  logic [CODE_W-1:0] wr_code;
  logic              wr_ready;

  logic              clr_req;
  logic [PG_W-1:0]   clr_page;
  logic [CODE_W-1:0] clr_code;
  logic              busy;
  logic              clr_done;

  menu_state_e       dbg_state;

  modport master (
    output char_xy, page_sel, wr_en, wr_page, wr_xy, wr_code,
           clr_req, clr_page, clr_code,
    input  char_code, wr_ready, busy, clr_done, dbg_state
  );

  modport slave (
    input  char_xy, page_sel, wr_en, wr_page, wr_xy, wr_code,
           clr_req, clr_page, clr_code,
    output char_code, wr_ready, busy, clr_done, dbg_state
  );
endinterface

// File: rtl/menu_text_buffer_text_ram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port, read-first
// on address collision. No reset so it maps onto block or distributed RAM.
module text_ram_1r1w #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 7,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/menu_text_buffer.sv
// Multi-page character buffer for the menu/char-render path: cell writes,
// whole-page fill sweeps and a post-reset init sweep, with a 1-cycle read port.
module menu_text_buffer
  import menu_text_buffer_pkg::*;
#(
  parameter int COLS   = MENU_COLS,
  parameter int ROWS   = MENU_ROWS,
  parameter int CODE_W = MENU_CODE_W,
  parameter int PAGES  = MENU_PAGES,
  parameter logic [CODE_W-1:0] FILL_CODE = CODE_W'(MENU_FILL_CODE)
) (
  input logic clk,
  input logic rst_n,
  menu_text_buffer_if.slave bus
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int PG_W  = pg_width(PAGES);
  localparam int XY_W  = ROW_W + COL_W;
  localparam int CELLS = ROWS * COLS;
  localparam int DEPTH = PAGES * CELLS;
  localparam int AW    = $clog2(DEPTH);
  // Wide enough for page*CELLS + row*COLS + col with any out-of-range inputs.
  localparam int LIN_W = PG_W + XY_W + 2;
  localparam logic [AW-1:0] INIT_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] CLR_LAST  = AW'(CELLS - 1);

  function automatic logic [LIN_W-1:0] lin_addr(input logic [PG_W-1:0] pg,
                                                input logic [XY_W-1:0] xy);
    return LIN_W'(pg) * LIN_W'(CELLS) + LIN_W'(xy[XY_W-1:COL_W]) * LIN_W'(COLS)
         + LIN_W'(xy[COL_W-1:0]);
  endfunction

  function automatic logic in_range(input logic [PG_W-1:0] pg,
                                    input logic [XY_W-1:0] xy);
    return (LIN_W'(xy[COL_W-1:0]) < LIN_W'(COLS)) &&
           (LIN_W'(xy[XY_W-1:COL_W]) < LIN_W'(ROWS)) &&
           (LIN_W'(pg) < LIN_W'(PAGES));
  endfunction

  menu_state_e       state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [PG_W-1:0]   clr_page_q, clr_page_d;
  logic [CODE_W-1:0] clr_code_q, clr_code_d;
  logic              ovr_q, ovr_d;
  logic [CODE_W-1:0] ovr_code_q, ovr_code_d;

  logic              clr_accept, last_cell, rd_ok;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr, ram_raddr;
  logic [CODE_W-1:0] ram_wdata, ram_rdata;

  assign clr_accept = (state_q == ST_IDLE) && bus.clr_req &&
                      (LIN_W'(bus.clr_page) < LIN_W'(PAGES));
  assign last_cell  = ((state_q == ST_INIT)  && (cnt_q == INIT_LAST)) ||
                      ((state_q == ST_CLEAR) && (cnt_q == CLR_LAST));
  assign rd_ok      = in_range(bus.page_sel, bus.char_xy);
  assign ram_raddr  = rd_ok ? AW'(lin_addr(bus.page_sel, bus.char_xy)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      clr_page_q <= '0;
      clr_code_q <= '0;
      ovr_q      <= 1'b1;
      ovr_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_page_q <= clr_page_d;
      clr_code_q <= clr_code_d;
      ovr_q      <= ovr_d;
      ovr_code_q <= ovr_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_page_d = clr_page_q;
    clr_code_d = clr_code_q;
    unique case (state_q)
      ST_INIT, ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (last_cell) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (clr_accept) begin
          state_d    = ST_CLEAR;
          cnt_d      = '0;
          clr_page_d = bus.clr_page;
          clr_code_d = bus.clr_code;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // The page under a sweep reads as its final value regardless of progress.
    ovr_d      = 1'b0;
    ovr_code_d = FILL_CODE;
    if (state_q == ST_INIT || !rd_ok) begin
      ovr_d = 1'b1;
    end else if (state_q == ST_CLEAR && bus.page_sel == clr_page_q) begin
      ovr_d      = 1'b1;
      ovr_code_d = clr_code_q;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = FILL_CODE;
    unique case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = AW'(LIN_W'(clr_page_q) * LIN_W'(CELLS) + LIN_W'(cnt_q));
        ram_wdata = clr_code_q;
      end
      ST_IDLE: begin
        ram_we    = bus.wr_en && in_range(bus.wr_page, bus.wr_xy);
        ram_waddr = AW'(lin_addr(bus.wr_page, bus.wr_xy));
        ram_wdata = bus.wr_code;
      end
      default: ;
    endcase

    bus.wr_ready  = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.clr_done  = last_cell;
    bus.dbg_state = state_q;
    bus.char_code = ovr_q ? ovr_code_q : ram_rdata;
  end

  text_ram_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );
endmodule

// File: tb/tb_menu_text_buffer.sv
// Directed bench for menu_text_buffer (16x16, 2 pages, fill code 7'h00).
module tb_menu_text_buffer;
  import menu_text_buffer_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  menu_text_buffer_if #(.XY_W(8), .PG_W(1), .CODE_W(7)) bus ();

  menu_text_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.char_xy  = '0;
    bus.page_sel = '0;
    bus.wr_en    = 1'b0;
    bus.wr_page  = '0;
    bus.wr_xy    = '0;
    bus.wr_code  = '0;
    bus.clr_req  = 1'b0;
    bus.clr_page = '0;
    bus.clr_code = '0;
  endtask

  task automatic write_cell(input logic pg, input logic [7:0] xy, input logic [6:0] code);
    bus.wr_en   = 1'b1;
    bus.wr_page = pg;
    bus.wr_xy   = xy;
    bus.wr_code = code;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic pg, input logic [7:0] xy,
                          input logic [6:0] exp);
    bus.page_sel = pg;
    bus.char_xy  = xy;
    tick();
    chk(name, 32'(bus.char_code), 32'(exp));
  endtask

  // Runs the init sweep from just after reset release; checks busy length,
  // single clr_done, wr_ready as the inverse of busy and reads of FILL_CODE.
  task automatic wait_init(input string tag);
    int busy_n, done_n, rdy_bad, rd_bad;
    busy_n = 0; done_n = 0; rdy_bad = 0; rd_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (bus.char_code !== 7'h00) rd_bad++;
      if (!bus.busy) break;
      busy_n++;
      if (bus.clr_done) done_n++;
      if (bus.wr_ready) rdy_bad++;
      bus.char_xy  = 8'(i * 37);
      bus.page_sel = 1'(i);
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd512);
    chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    chk({tag, "_ready_while_busy"}, 32'(rdy_bad), 32'd0);
    chk({tag, "_reads_during_init"}, 32'(rd_bad), 32'd0);
    chk({tag, "_ready_after"}, 32'(bus.wr_ready), 32'd1);
  endtask

  task automatic check_page(input string name, input logic pg, input logic [6:0] exp);
    int nbad;
    nbad = 0;
    for (int xy = 0; xy < 256; xy++) begin
      bus.page_sel = pg;
      bus.char_xy  = 8'(xy);
      tick();
      if (bus.char_code !== exp) nbad++;
    end
    chk(name, 32'(nbad), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 600) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       is_wr;
    logic       pg;
    logic [7:0] xy;
    logic [6:0] code;   // write data, or expected read data
  } vec_t;

  vec_t vecs[12];

  // ---------------- main sequence ----------------
  initial begin
    int busy_n, done_n, rdy_bad, rd_bad;
    total = 0;
    bad   = 0;
    vecs[0]  = '{1'b1, 1'b1, 8'h23, 7'h4D};
    vecs[1]  = '{1'b0, 1'b1, 8'h23, 7'h4D};
    vecs[2]  = '{1'b0, 1'b0, 8'h23, 7'h00};
    vecs[3]  = '{1'b1, 1'b0, 8'hFF, 7'h11};
    vecs[4]  = '{1'b0, 1'b0, 8'hFF, 7'h11};
    vecs[5]  = '{1'b0, 1'b1, 8'hFF, 7'h00};
    vecs[6]  = '{1'b1, 1'b1, 8'h00, 7'h7F};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 7'h7F};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 7'h00};
    vecs[9]  = '{1'b1, 1'b0, 8'h23, 7'h55};
    vecs[10] = '{1'b0, 1'b0, 8'h23, 7'h55};
    vecs[11] = '{1'b0, 1'b1, 8'h23, 7'h4D};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_clr_done", 32'(bus.clr_done), 32'd0);
    chk("rst_char_code", 32'(bus.char_code), 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_INIT));

    rst_n = 1'b1;
    wait_init("init");
    check_page("init_page0", 1'b0, 7'h00);
    check_page("init_page1", 1'b1, 7'h00);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) write_cell(vecs[i].pg, vecs[i].xy, vecs[i].code);
      else read_chk($sformatf("vec%0d", i), vecs[i].pg, vecs[i].xy, vecs[i].code);
    end

    // Read-during-write to the same cell returns the old value.
    bus.page_sel = 1'b0;
    bus.char_xy  = 8'h05;
    write_cell(1'b0, 8'h05, 7'h41);
    chk("rdw_old", 32'(bus.char_code), 32'h00);
    tick();
    chk("rdw_new", 32'(bus.char_code), 32'h41);

    // Page-0 clear; writes and further clear requests offered meanwhile are dropped.
    bus.clr_req  = 1'b1;
    bus.clr_page = 1'b0;
    bus.clr_code = 7'h30;
    tick();
    bus.clr_page = 1'b1;
    bus.clr_code = 7'h55;
    busy_n = 0; done_n = 0; rdy_bad = 0; rd_bad = 0;
    for (int i = 0; i < 600; i++) begin
      logic [6:0] exp;
      if (!bus.busy) break;
      busy_n++;
      if (bus.clr_done) done_n++;
      if (bus.wr_ready) rdy_bad++;
      bus.clr_req  = (i < 10);
      bus.wr_en    = 1'b1;
      bus.wr_page  = 1'b1;
      bus.wr_xy    = 8'h23;
      bus.wr_code  = 7'h01;
      bus.page_sel = 1'(i);
      bus.char_xy  = (i % 2 == 0) ? 8'(i) : 8'h23;
      exp          = (i % 2 == 0) ? 7'h30 : 7'h4D;
      tick();
      if (bus.char_code !== exp) rd_bad++;
    end
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;
    chk("clr_busy_cycles", 32'(busy_n), 32'd256);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    chk("clr_ready_while_busy", 32'(rdy_bad), 32'd0);
    chk("clr_reads", 32'(rd_bad), 32'd0);
    check_page("clr_page0", 1'b0, 7'h30);
    read_chk("clr_p1_23", 1'b1, 8'h23, 7'h4D);
    read_chk("clr_p1_00", 1'b1, 8'h00, 7'h7F);
    read_chk("clr_p1_ff", 1'b1, 8'hFF, 7'h00);

    // Write and clear request in the same idle cycle: clear wins on that cell.
    bus.wr_en    = 1'b1;
    bus.wr_page  = 1'b0;
    bus.wr_xy    = 8'hFF;
    bus.wr_code  = 7'h07;
    bus.clr_req  = 1'b1;
    bus.clr_page = 1'b0;
    bus.clr_code = 7'h12;
    tick();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;
    chk("sim_busy", 32'(bus.busy), 32'd1);
    wait_idle("sim_idle");
    read_chk("sim_cell", 1'b0, 8'hFF, 7'h12);
    read_chk("sim_other", 1'b1, 8'h00, 7'h7F);

    // Reset in the middle of a page-1 clear.
    bus.clr_req  = 1'b1;
    bus.clr_page = 1'b1;
    bus.clr_code = 7'h66;
    bus.page_sel = 1'b0;
    bus.char_xy  = 8'hFF;
    tick();
    bus.clr_req = 1'b0;
    repeat (100) tick();
    chk("mid_char_code", 32'(bus.char_code), 32'h12);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd1);
    chk("arst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("arst_clr_done", 32'(bus.clr_done), 32'd0);
    chk("arst_char_code", 32'(bus.char_code), 32'd0);
    chk("arst_state", 32'(bus.dbg_state), 32'(ST_INIT));
    tick();
    rst_n = 1'b1;
    wait_init("reinit");
    check_page("reinit_page0", 1'b0, 7'h00);
    check_page("reinit_page1", 1'b1, 7'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/menu_text_buffer.md
Name: menu_text_buffer

Overview:
- Writable, multi-page character buffer. It is the parametrised successor of the fixed per-screen menu text tables.
- Holds PAGES screens of COLS x ROWS character codes. The display path reads one page with 1-cycle latency while game or menu logic writes individual cells.
- A built-in sweep engine fills a whole page with one code. All pages are filled with FILL_CODE automatically after reset.
- Sits between the menu/game control logic and the font/char-render stage of the VGA pipeline.

Parameters:
- COLS, 16, characters per row (>=2)
- ROWS, 16, rows per page (>=2)
- CODE_W, 7, character code width
- PAGES, 2, number of independent screens (>=1)
- FILL_CODE, 7'h00, code written by the post-reset init sweep
- Derived (localparam): COL_W=$clog2(COLS), ROW_W=$clog2(ROWS), PG_W=max(1,$clog2(PAGES)), XY_W=ROW_W+COL_W, CELLS=ROWS*COLS

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- char_xy  in  XY_W  display read address {row, col}
- page_sel  in  PG_W  page shown on display
- char_code  out  CODE_W  registered code for (page_sel, char_xy)
- wr_en  in  1  cell write request
- wr_page  in  PG_W  write page
- wr_xy  in  XY_W  write address {row, col}
- wr_code  in  CODE_W  write data
- wr_ready  out  1  write accepted this cycle when wr_en & wr_ready
- clr_req  in  1  page fill request
- clr_page  in  PG_W  page to fill
- clr_code  in  CODE_W  fill code
- busy  out  1  init or clear sweep in progress
- clr_done  out  1  one-cycle pulse when a sweep finishes

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). The storage array itself is not reset.
- Reset values:
  - char_code=0, clr_done=0, wr_ready=0, busy=1.
  - FSM=INIT, sweep counter=0.
- FSM states: INIT, IDLE, CLEAR.
- INIT:
  - Writes FILL_CODE to one cell per cycle across every page, PAGES*CELLS cycles in total.
  - Counter order: page-major, then row, then col.
  - On the last cell: clr_done pulses for 1 cycle and the FSM goes to IDLE.
  - clr_req is ignored during INIT (not queued).
- IDLE:
  - wr_ready=1 and busy=0.
  - clr_req=1 latches clr_page and clr_code, and the FSM goes to CLEAR next cycle.
  - clr_req with clr_page >= PAGES is ignored.
- CLEAR:
  - Writes the latched code to the latched page, one cell per cycle, CELLS cycles.
  - Last cell: clr_done pulse, return to IDLE.
  - clr_req during CLEAR is ignored.
- busy=1 in INIT and CLEAR. wr_ready=0 in INIT and CLEAR. Writes offered while wr_ready=0 are dropped; the requester must hold wr_en until it sees wr_ready.
- Simultaneous clr_req and wr_en in IDLE: the write is performed in that cycle and the clear starts next cycle, so the clear overwrites it.
- Read path:
  - char_code is valid 1 cycle after char_xy and page_sel.
  - Read-during-write to the same cell returns the OLD value (read-first).
  - While CLEAR sweeps page P, reads of page P return the latched clr_code regardless of sweep progress. Reads of other pages return stored data.
  - During INIT, all reads return FILL_CODE.
- Range checks:
  - Addresses with col >= COLS, row >= ROWS or page >= PAGES: writes are ignored and reads return FILL_CODE. Only reachable for non-power-of-two parameters.
- Sweep counter:
  - Width covers PAGES*CELLS-1 and must not wrap inside a sweep.
  - Reset mid-sweep aborts it and restarts INIT.
- Linear address = page*CELLS + row*COLS + col. Computed in full width, with no truncation before comparison.

Decomposition:
- Shared vga_pkg gets: a typedef for the menu FSM state enum (INIT/IDLE/CLEAR), localparams MENU_COLS, MENU_ROWS, MENU_CODE_W, and named blank/fill codes.
- Natural sub-module: text_ram_1r1w. A simple dual-port, read-first, registered-read RAM with parameters DEPTH and WIDTH. It maps to BRAM/LUTRAM.
- menu_text_buffer keeps the FSM, the address mux (sweep vs. user write) and the range/clear-override logic on the read data.

Test Plan (COLS=16, ROWS=16, PAGES=2, FILL_CODE=7'h00):
- Release rst_n and read all cells -> busy=1, wr_ready=0 for exactly 512 cycles; a single clr_done pulse; afterwards busy=0 and every cell of both pages reads 7'h00.
- After init, write page 1 xy=8'h23 code 7'h4D, then read it with page_sel=1 -> 7'h4D one cycle after the address; page 0 xy=8'h23 still reads 7'h00.
- Same-cycle write 7'h41 and read of page 0 xy=8'h05 -> char_code shows the old 7'h00; the next read shows 7'h41.
- clr_req page 0 code 7'h30 -> busy for 256 cycles; page-0 reads return 7'h30 throughout; page-1 data is preserved; wr_en is dropped and wr_ready=0 while busy; clr_done pulses once.
- clr_req and wr_en (page 0, 8'hFF, 7'h07) in the same IDLE cycle -> the write occurs, then the cell reads the clear code after clr_done.
- Assert rst_n=0 at cycle 100 of a CLEAR -> outputs return to reset values asynchronously, then a full 512-cycle INIT leaves all cells 7'h00.
